// File: rtl/pheap_level.sv
// Pipelined heap priority queue: shared types and the generic level stage.
//
// pheapTypes holds the heap geometry and the key/value, entry, opcode and
// handshake types shared by every stage of the heap pipeline.
//
// pheap_level: intermediate/leaf stage for heap level LEV (root is level 1).
// Owns the 2^(LEV-1) nodes of its level and, on a hand-off from the level
// above, performs one LEQ sift-down step or one DEQ refill step on one node.
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op, in      hand-off strobe, opcode and key/value from upstream
//   idx_in             node index targeted at this level
//   rd_pair            pair select for the upstream read port
//   rTopL, rTopR       combinational read of the selected node pair
//   rBotL, rBotR       children of the processed node, read from the level below
//   done               DONE / WAIT / NEXT_LEVEL
//   raddrBot, endPos   pair index and child side handed to the level below
//   out                key/value passed to the level below (LEQ)
//   ovf                one-cycle pulse when a leaf LEQ discards a key

package pheapTypes;
  localparam int unsigned LEVELS = 3;
  localparam int unsigned KEY_W  = 8;
  localparam int unsigned VAL_W  = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  typedef struct packed {
    kv_t               kv;
    logic [LEVELS-1:0] capacity;
    logic              active;
  } entry_t;

  typedef enum logic {LEQ = 1'b0, DEQ = 1'b1} opcode_t;

  typedef enum logic [1:0] {DONE = 2'd0, WAIT = 2'd1, NEXT_LEVEL = 2'd2} done_t;

  localparam kv_t KV_EMPTY = '0;
endpackage

module pheap_level
  import pheapTypes::*;
#(
  parameter int unsigned  LEV = 2,
  localparam int unsigned NW  = LEV - 1,
  localparam int unsigned RPW = (NW > 1) ? NW - 1 : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  opcode_t       op,
  input  kv_t           in,
  input  logic [NW-1:0] idx_in,
  input  logic [RPW-1:0] rd_pair,
  output entry_t        rTopL,
  output entry_t        rTopR,
  input  entry_t        rBotL,
  input  entry_t        rBotR,
  output done_t         done,
  output logic [NW-1:0] raddrBot,
  output logic          endPos,
  output kv_t           out,
  output logic          ovf
);

  localparam int unsigned       Depth  = 1 << NW;
  localparam logic [LEVELS-1:0] CAP0   = LEVELS'((1 << (LEVELS - LEV + 1)) - 1);
  localparam bit                IsLeaf = (LEV == LEVELS);
  localparam entry_t RstEntry = '{kv: KV_EMPTY, capacity: CAP0, active: 1'b0};

  typedef enum logic {StIdle, StProc} state_e;

  state_e        state_q;
  opcode_t       op_q;
  kv_t           kv_q;
  logic [NW-1:0] idx_q;
  entry_t        mem_q [Depth];

  entry_t            n;
  entry_t            wr_entry;
  logic              wr_en;
  logic [LEVELS-1:0] cap_inc;
  logic              l_has_cap;
  logic              r_has_cap;
  logic [NW-1:0]     rd_l;
  logic [NW-1:0]     rd_r;

  // Pair addresses wrap mod 2^NW; at NW==1 this always selects nodes 0 and 1.
  assign rd_l  = NW'({rd_pair, 1'b0});
  assign rd_r  = NW'({rd_pair, 1'b1});
  assign rTopL = mem_q[rd_l];
  assign rTopR = mem_q[rd_r];

  always_comb begin
    n         = mem_q[idx_q];
    done      = DONE;
    endPos    = 1'b0;
    raddrBot  = '0;
    out       = KV_EMPTY;
    ovf       = 1'b0;
    wr_en     = 1'b0;
    wr_entry  = n;
    l_has_cap = (rBotL.capacity != '0);
    r_has_cap = (rBotR.capacity != '0);
    // Saturate before incrementing so an out-of-range capacity cannot wrap.
    cap_inc   = (n.capacity >= CAP0) ? CAP0 : n.capacity + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done = WAIT;
        end
      end
      StProc: begin
        raddrBot = idx_q;
        wr_en    = 1'b1;
        if (op_q == LEQ) begin
          if (!n.active) begin
            wr_entry.kv       = kv_q;
            wr_entry.capacity = n.capacity - 1'b1;
            wr_entry.active   = 1'b1;
          end else begin
            wr_entry.capacity = (n.capacity == '0) ? '0 : n.capacity - 1'b1;
            // Larger key stays here; a tie keeps the resident entry.
            if (kv_q.key > n.kv.key) begin
              wr_entry.kv = kv_q;
              out         = n.kv;
            end else begin
              out         = kv_q;
            end
            if (IsLeaf) begin
              ovf = 1'b1;
            end else begin
              done = NEXT_LEVEL;
              if (l_has_cap && r_has_cap) begin
                endPos = (rBotL.kv.key <= rBotR.kv.key) ? 1'b0 : 1'b1;
              end else if (l_has_cap) begin
                endPos = 1'b0;
              end else begin
                endPos = 1'b1;
              end
            end
          end
        end else begin
          wr_entry.capacity = cap_inc;
          if (rBotL.active && rBotR.active) begin
            done            = NEXT_LEVEL;
            wr_entry.active = 1'b1;
            if (rBotL.kv.key >= rBotR.kv.key) begin
              wr_entry.kv = rBotL.kv;
              endPos      = 1'b0;
            end else begin
              wr_entry.kv = rBotR.kv;
              endPos      = 1'b1;
            end
          end else if (rBotL.active) begin
            done            = NEXT_LEVEL;
            wr_entry.active = 1'b1;
            wr_entry.kv     = rBotL.kv;
            endPos          = 1'b0;
          end else if (rBotR.active) begin
            done            = NEXT_LEVEL;
            wr_entry.active = 1'b1;
            wr_entry.kv     = rBotR.kv;
            endPos          = 1'b1;
          end else begin
            wr_entry.kv     = KV_EMPTY;
            wr_entry.active = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= LEQ;
      kv_q    <= KV_EMPTY;
      idx_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= RstEntry;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StProc;
            op_q    <= op;
            kv_q    <= in;
            idx_q   <= idx_in;
          end
        end
        StProc:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (wr_en) begin
        mem_q[idx_q] <= wr_entry;
      end
    end
  end

endmodule

// File: tb/tb_pheap_level.sv
// Bench for pheap_level: one instance at LEV=2 (children driven by the bench)
// and one leaf instance at LEV=LEVELS=3 (children tied off), checked against
// a node-array reference model of the heap level.

module tb_pheap_level;
  import pheapTypes::*;

  typedef logic [LEVELS-1:0] cap_t;

  logic clk;
  logic rst_n;

  logic    st2;
  opcode_t op2;
  kv_t     in2;
  logic    [0:0] idx2;
  logic    [0:0] rp2;
  entry_t  tl2, tr2, bl2, br2;
  done_t   d2;
  logic    [0:0] rab2;
  logic    ep2;
  kv_t     out2;
  logic    ovf2;

  logic    st3;
  opcode_t op3;
  kv_t     in3;
  logic    [1:0] idx3;
  logic    [0:0] rp3;
  entry_t  tl3, tr3, tie3;
  done_t   d3;
  logic    [1:0] rab3;
  logic    ep3;
  kv_t     out3;
  logic    ovf3;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_start = -10;

  entry_t m2 [2];
  entry_t m3 [4];

  assign tie3 = '{kv: KV_EMPTY, capacity: '0, active: 1'b0};

  pheap_level #(.LEV(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .op(op2), .in(in2), .idx_in(idx2),
    .rd_pair(rp2), .rTopL(tl2), .rTopR(tr2), .rBotL(bl2), .rBotR(br2), .done(d2),
    .raddrBot(rab2), .endPos(ep2), .out(out2), .ovf(ovf2)
  );

  pheap_level #(.LEV(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .op(op3), .in(in3), .idx_in(idx3),
    .rd_pair(rp3), .rTopL(tl3), .rTopR(tr3), .rBotL(tie3), .rBotR(tie3), .done(d3),
    .raddrBot(rab3), .endPos(ep3), .out(out3), .ovf(ovf3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cap0_of(input int lev);
    return (1 << (LEVELS - lev + 1)) - 1;
  endfunction

  function automatic entry_t mk(input int key, input int val, input int cap, input bit act);
    entry_t e;
    e.kv.key   = KEY_W'(key);
    e.kv.value = VAL_W'(val);
    e.capacity = cap_t'(cap);
    e.active   = act;
    return e;
  endfunction

  function automatic kv_t mkkv(input int key, input int val);
    kv_t k;
    k.key   = KEY_W'(key);
    k.value = VAL_W'(val);
    return k;
  endfunction

  function automatic entry_t rand_child();
    return mk($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1),
              1'($urandom_range(0, 1)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m2[i] = mk(0, 0, cap0_of(2), 1'b0);
    for (int i = 0; i < 4; i++) m3[i] = mk(0, 0, cap0_of(3), 1'b0);
  endtask

  // One node operation: new node contents plus the hand-off to the level below.
  function automatic void model(input int lev, input opcode_t o, input kv_t k,
                                input entry_t n, input entry_t l, input entry_t r,
                                output entry_t nn, output done_t d, output bit ep,
                                output kv_t ko, output bit ov);
    int cap;
    int c0;
    cap = int'(n.capacity);
    c0  = cap0_of(lev);
    nn  = n;
    d   = DONE;
    ep  = 1'b0;
    ko  = KV_EMPTY;
    ov  = 1'b0;
    if (o == LEQ) begin
      if (!n.active) begin
        nn.kv = k;
        nn.capacity = cap_t'(cap - 1);
        nn.active = 1'b1;
      end else begin
        nn.capacity = cap_t'((cap == 0) ? 0 : cap - 1);
        if (k.key > n.kv.key) begin
          nn.kv = k;
          ko = n.kv;
        end else begin
          ko = k;
        end
        if (lev == LEVELS) begin
          ov = 1'b1;
        end else begin
          d = NEXT_LEVEL;
          if (l.capacity != 0 && r.capacity != 0) ep = (l.kv.key > r.kv.key);
          else ep = (l.capacity == 0);
        end
      end
    end else begin
      nn.capacity = cap_t'((cap + 1 > c0) ? c0 : cap + 1);
      if (!l.active && !r.active) begin
        nn.kv = KV_EMPTY;
        nn.active = 1'b0;
      end else begin
        d = NEXT_LEVEL;
        nn.active = 1'b1;
        ep = !l.active || (r.active && r.kv.key > l.kv.key);
        nn.kv = ep ? r.kv : l.kv;
      end
    end
  endfunction

  task automatic check_mem(input int lev, input string tag);
    if (lev == 2) begin
      check({tag, "_l2_n0"}, 64'(tl2), 64'(m2[0]));
      check({tag, "_l2_n1"}, 64'(tr2), 64'(m2[1]));
    end else begin
      for (int p = 0; p < 2; p++) begin
        rp3 = 1'(p);
        #1;
        check({tag, "_l3_even"}, 64'(tl3), 64'(m3[2*p]));
        check({tag, "_l3_odd"}, 64'(tr3), 64'(m3[2*p+1]));
      end
    end
  endtask

  // Called shortly after a posedge with the stage idle; returns in the same phase.
  task automatic run_op(input int lev, input opcode_t o, input kv_t k, input int idx,
                        input entry_t l, input entry_t r);
    entry_t n, nn, le, re;
    done_t  ed;
    bit     eep, eov;
    kv_t    eo;
    if (cyc + 1 - last_start < 2) begin
      $display("FAIL start_spacing: observed %0d cycles required 2", cyc + 1 - last_start);
      $fatal(1, "start issued while stage busy");
    end
    last_start = cyc + 1;
    if (lev == 2) begin
      st2 = 1'b1; op2 = o; in2 = k; idx2 = 1'(idx);
    end else begin
      st3 = 1'b1; op3 = o; in3 = k; idx3 = 2'(idx);
    end
    #1;
    check("start_wait", 64'((lev == 2) ? d2 : d3), 64'(WAIT));
    @(posedge clk);
    #1;
    st2 = 1'b0;
    st3 = 1'b0;
    if (lev == 2) begin
      bl2 = l; br2 = r; le = l; re = r;
    end else begin
      le = tie3; re = tie3;
    end
    #1;
    n = (lev == 2) ? m2[idx] : m3[idx];
    model(lev, o, k, n, le, re, nn, ed, eep, eo, eov);
    if (lev == 2) begin
      check("proc_done", 64'(d2), 64'(ed));
      check("proc_endpos", 64'(ep2), 64'(eep));
      check("proc_raddr", 64'(rab2), 64'(idx));
      check("proc_out", 64'(out2), 64'(eo));
      check("proc_ovf", 64'(ovf2), 64'(eov));
    end else begin
      check("proc_done", 64'(d3), 64'(ed));
      check("proc_endpos", 64'(ep3), 64'(eep));
      check("proc_raddr", 64'(rab3), 64'(idx));
      check("proc_out", 64'(out3), 64'(eo));
      check("proc_ovf", 64'(ovf3), 64'(eov));
    end
    @(posedge clk);
    #1;
    if (lev == 2) m2[idx] = nn;
    else m3[idx] = nn;
    check("idle_done", 64'((lev == 2) ? d2 : d3), 64'(DONE));
    check("idle_ovf", 64'((lev == 2) ? ovf2 : ovf3), 64'd0);
    check_mem(lev, "after");
  endtask

  initial begin
    entry_t cl, cr;
    int lev, idx;
    opcode_t o;
    rst_n = 1'b1;
    st2 = 1'b0; op2 = LEQ; in2 = KV_EMPTY; idx2 = '0; rp2 = '0; bl2 = '0; br2 = '0;
    st3 = 1'b0; op3 = LEQ; in3 = KV_EMPTY; idx3 = '0; rp3 = '0;
    model_reset();

    // Asynchronous reset pulse mid-cycle; read port shows reset entries at once.
    #2 rst_n = 1'b0;
    #1;
    check("rst_done", 64'(d2), 64'(DONE));
    check("rst_out", 64'(out2), 64'(KV_EMPTY));
    check("rst_ovf3", 64'(ovf3), 64'd0);
    check("rst_n0", 64'(tl2), 64'(mk(0, 0, 3, 1'b0)));
    check("rst_n1", 64'(tr2), 64'(mk(0, 0, 3, 1'b0)));
    check_mem(3, "rst");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LEQ into an empty node.
    run_op(2, LEQ, mkkv(5, 8'h15), 1, mk(0, 0, 1, 1'b0), mk(0, 0, 1, 1'b0));
    check("plan_leq_empty", 64'(tr2), 64'(mk(5, 8'h15, 2, 1'b1)));

    // Sift-down: node 0 holds 9/cap2, new key 12 pushes 9 to the left child.
    run_op(2, LEQ, mkkv(9, 8'h09), 0, mk(0, 0, 1, 1'b0), mk(0, 0, 1, 1'b0));
    run_op(2, LEQ, mkkv(12, 8'h0c), 0, mk(3, 8'h03, 1, 1'b1), mk(7, 8'h07, 1, 1'b1));
    check("plan_siftdown", 64'(tl2), 64'(mk(12, 8'h0c, 1, 1'b1)));

    // DEQ refill from the larger child, then from no children.
    run_op(2, LEQ, mkkv(8, 8'h08), 1, mk(0, 0, 1, 1'b0), mk(0, 0, 1, 1'b0));
    run_op(2, DEQ, KV_EMPTY, 1, mk(4, 8'h44, 1, 1'b1), mk(6, 8'h66, 1, 1'b1));
    check("plan_deq_refill", 64'(tr2), 64'(mk(6, 8'h66, 2, 1'b1)));
    run_op(2, DEQ, KV_EMPTY, 1, mk(0, 0, 1, 1'b0), mk(0, 0, 1, 1'b0));
    check("plan_deq_empty", 64'(tr2), 64'(mk(0, 0, 3, 1'b0)));

    // Leaf overflow.
    run_op(3, LEQ, mkkv(10, 8'h0a), 2, tie3, tie3);
    run_op(3, LEQ, mkkv(2, 8'h02), 2, tie3, tie3);
    rp3 = 1'b1;
    #1;
    check("plan_leaf_ovf", 64'(tl3), 64'(mk(10, 8'h0a, 0, 1'b1)));

    // Reset during PROC abandons the operation.
    st2 = 1'b1; op2 = LEQ; in2 = mkkv(99, 1); idx2 = 1'b0;
    @(posedge clk);
    #1;
    st2 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rstproc_done", 64'(d2), 64'(DONE));
    check("rstproc_raddr", 64'(rab2), 64'd0);
    check_mem(2, "rstproc");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstproc_idle", 64'(d2), 64'(DONE));
    check_mem(2, "rstproc_after");
    check_mem(3, "rstproc_after");
    last_start = -10;

    // Randomized traffic on both stages.
    for (int i = 0; i < 60; i++) begin
      lev = (i % 3 == 2) ? 3 : 2;
      idx = (lev == 2) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      o   = ($urandom_range(0, 2) == 0) ? DEQ : LEQ;
      cl  = rand_child();
      cr  = rand_child();
      rp2 = 1'($urandom_range(0, 1));
      run_op(lev, o, mkkv($urandom_range(0, 15), $urandom_range(0, 255)), idx, cl, cr);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pheap_level.md
Name: pheap_level

Overview:
- Generic intermediate/leaf stage of the pipelined heap priority queue. Instantiated once per level LEV = 2..LEVELS, directly downstream of the root stage or of the previous pheap_level.
- Owns the 2^(LEV-1) node entries of its level and serves the pair-read port that the level above uses as its rBotL/rBotR.
- On a NEXT_LEVEL hand-off from above, it performs the LEQ sift-down or DEQ refill for one node. It then either terminates the operation (DONE) or hands it to the level below (NEXT_LEVEL).

Parameters:
- LEV, 2: heap level implemented by this instance (root is level 1). Legal range is 2..LEVELS.
- LEVELS (from pheapTypes), package constant: total number of heap levels.
- NW, LEV-1: node-index width at this level (derived).
- CAP0, 2^(LEVELS-LEV+1)-1: reset capacity of each node, i.e. the free slots in its subtree (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  hand-off strobe; high when the upstream stage's done==NEXT_LEVEL.
- op  in  opcode_t  LEQ/DEQ from upstream.
- in  in  kv_t  key/value carried down (upstream out).
- idx_in  in  NW  target node index = {upstream raddrBot, upstream endPos}, truncated to NW bits.
- rd_pair  in  max(NW-1,1)  pair select from upstream (its raddrBot).
- rTopL, rTopR  out  entry_t  combinational read of entries (2*rd_pair) mod 2^NW and (2*rd_pair+1) mod 2^NW.
- rBotL, rBotR  in  entry_t  children read from the level below. Tied to inactive/capacity 0 when LEV==LEVELS.
- done  out  done_t  DONE / WAIT / NEXT_LEVEL.
- raddrBot  out  NW  pair index presented to the level below (= latched index).
- endPos  out  1  child selected at the level below (0=left, 1=right).
- out  out  kv_t  value passed to the level below (LEQ only).
- ovf  out  1  one-cycle pulse: LEQ reached an active leaf and the smaller key was discarded.

Behaviour:
- Storage: mem[0..2^NW-1] of entry_t, held in flops.
  - Reset (rst_n low, asynchronous) sets every entry to {KV_EMPTY, CAP0, active=0}, state=IDLE, and clears the latches.
  - Reset takes effect immediately, including mid-operation; any in-flight operation is abandoned with no write.
- Combinational output defaults: done=DONE, endPos=0, raddrBot=0, out=KV_EMPTY, ovf=0.
  - These are the values held during reset and in IDLE without start.
- FSM has two states, IDLE and PROC.
- IDLE:
  - If start is high: done=WAIT; latch op, in and idx_in into op_q, kv_q and idx_q; next state=PROC.
  - Otherwise stay in IDLE.
- PROC (exactly one cycle, then back to IDLE):
  - n = mem[idx_q]; raddrBot = idx_q.
  - The write to mem[idx_q] occurs at the end of PROC.
  - LEQ, n inactive: write {kv_q, n.capacity-1, active=1}; done=DONE.
  - LEQ, n active:
    - Keep max(n.kv.key, kv_q.key) in the node. On a tie keep n.kv.
    - Drive out = the other value.
    - Capacity = (n.capacity==0) ? 0 : n.capacity-1.
    - If LEV==LEVELS: done=DONE and ovf=1 (out is dropped).
    - Else done=NEXT_LEVEL, with endPos chosen as follows:
      - Both children have nonzero capacity: endPos = (rBotL.kv.key <= rBotR.kv.key) ? 0 : 1.
      - Only left has nonzero capacity: endPos=0.
      - Otherwise: endPos=1.
  - DEQ: capacity = n.capacity+1, saturating at CAP0.
    - No active child: write {KV_EMPTY, cap, 0}; done=DONE.
    - Both children active: copy the larger key (tie goes to left); endPos = its side; done=NEXT_LEVEL.
    - One child active: copy that child; endPos = its side; done=NEXT_LEVEL.
- Throughput and hazards:
  - Minimum start spacing is 2 cycles, which is guaranteed by the upstream 2-state FSM.
  - A start during PROC is ignored, and a bench assertion fires on it.
  - rTopL/rTopR read mem directly. The upstream SET_OUT cycle (≥1 cycle after this stage's PROC write) therefore sees updated data, and no bypass is needed.
- Width rules:
  - Capacity arithmetic uses LEVELS-bit unsigned values.
  - Key comparisons are unsigned on kv_t.key.
  - Index arithmetic wraps mod 2^NW.

Test Plan:
1. Reset: LEVELS=3, LEV=2. Pulse rst_n low asynchronously mid-cycle. Require mem[0..1] = {KV_EMPTY, cap=3, inactive}, done=DONE, out=KV_EMPTY, and rTopL/rTopR reflect the reset entries immediately.
2. LEQ into empty node: start, op=LEQ, in.key=5, idx_in=1. Require done=WAIT in that cycle; next cycle done=DONE; then mem[1]={5, cap 2, active}.
3. LEQ sift-down: mem[0] holds key 9 cap 2; children L={key 3, cap 1}, R={key 7, cap 1}; in.key=12, idx_in=0. Require in PROC: out.key=9, endPos=0, raddrBot=0, done=NEXT_LEVEL; then mem[0]={12, cap 1}.
4. DEQ refill: mem[1] holds key 8 cap 1; rBotL active key 4, rBotR active key 6. Require endPos=1, done=NEXT_LEVEL, mem[1]={6, cap 2}. Repeat with both children inactive: require mem[1] inactive, cap 3, done=DONE.
5. Leaf overflow: LEV=LEVELS=3; mem[2] is active key 10; LEQ with in.key=2. Require ovf=1 for one cycle, done=DONE, mem[2] key stays 10, capacity stays 0.
6. Back-to-back and reset in PROC: two starts spaced 2 cycles apart are both processed correctly. Asserting rst_n low during PROC produces no write and returns the FSM to IDLE.
